// File: rtl/vga_sync_generator.sv
// VGA raster counter and sync generator feeding the PPU's counter_H/counter_V inputs.
// Define VGA_BLANK_MASK_EN to add a display-aligned blanking mask on colour_out.
module vga_sync_generator #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pixel_en,
    output logic [9:0] counter_H,
    output logic [9:0] counter_V,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_end,
    output logic       frame_end,
    output logic [7:0] frame_count,
    input  logic       colour_in,
    output logic       colour_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] hCount_q, hCount_d;
    logic [9:0] vCount_q, vCount_d;
    logic [7:0] frameCount_q, frameCount_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       displayOn_q, displayOn_d;
    logic       lineEnd_q, lineEnd_d;
    logic       frameEnd_q, frameEnd_d;

    // Every flag is derived from the next counter values so it lines up with the counters it is presented with.
    always_comb begin
        hCount_d     = hCount_q;
        vCount_d     = vCount_q;
        frameCount_d = frameCount_q;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        displayOn_d  = displayOn_q;
        lineEnd_d    = 1'b0;
        frameEnd_d   = 1'b0;
        if (pixel_en) begin
            if (hCount_q == H_LAST) begin
                hCount_d = 10'd0;
                if (vCount_q == V_LAST) begin
                    vCount_d     = 10'd0;
                    frameCount_d = frameCount_q + 8'd1;
                end else begin
                    vCount_d = vCount_q + 10'd1;
                end
            end else begin
                hCount_d = hCount_q + 10'd1;
            end
            hsync_d     = (hCount_d >= HS_START && hCount_d <= HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync_d     = (vCount_d >= VS_START && vCount_d <= VS_END) ? SYNC_POL : ~SYNC_POL;
            displayOn_d = (hCount_d < H_ACT) && (vCount_d < V_ACT);
            lineEnd_d   = (hCount_d == H_LAST);
            frameEnd_d  = (hCount_d == H_LAST) && (vCount_d == V_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hCount_q     <= 10'd0;
            vCount_q     <= 10'd0;
            frameCount_q <= 8'd0;
            hsync_q      <= ~SYNC_POL;
            vsync_q      <= ~SYNC_POL;
            displayOn_q  <= 1'b0;
            lineEnd_q    <= 1'b0;
            frameEnd_q   <= 1'b0;
        end else begin
            hCount_q     <= hCount_d;
            vCount_q     <= vCount_d;
            frameCount_q <= frameCount_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            displayOn_q  <= displayOn_d;
            lineEnd_q    <= lineEnd_d;
            frameEnd_q   <= frameEnd_d;
        end
    end

    assign counter_H   = hCount_q;
    assign counter_V   = vCount_q;
    assign frame_count = frameCount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = displayOn_q;
    assign line_end    = lineEnd_q;
    assign frame_end   = frameEnd_q;

`ifdef VGA_BLANK_MASK_EN
    logic displayOnDly_q;

    // The PPU's colour arrives one pixel late, so the mask is delayed to match it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            displayOnDly_q <= 1'b0;
        end else if (pixel_en) begin
            displayOnDly_q <= displayOn_q;
        end
    end

    assign colour_out = colour_in & displayOnDly_q;
`else
    logic unused_colour_in;
    assign unused_colour_in = colour_in;
    assign colour_out       = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_generator.sv
// Self-checking bench for vga_sync_generator: default horizontal timing, shortened frame height.
// A position-index reference model checks every output on every cycle alongside directed step checks.
module tb_vga_sync_generator;

    localparam int HA = 640;
    localparam int HF = 16;
    localparam int HS = 96;
    localparam int HB = 48;
    localparam int VA = 6;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pixel_en = 1'b0;
    logic       colour_in = 1'b0;
    logic [9:0] counter_H;
    logic [9:0] counter_V;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic       line_end;
    logic       frame_end;
    logic [7:0] frame_count;
    logic       colour_out;

    int checkCount = 0;
    int passCount = 0;
    int failCount = 0;

    // Reference model: linear raster position within a frame plus expected outputs
    int mPos = 0;
    int mH = 0;
    int mV = 0;
    int mFc = 0;
    bit mHs = 1'b1;
    bit mVs = 1'b1;
    bit mDisp = 1'b0;
    bit mLe = 1'b0;
    bit mFe = 1'b0;
    bit mDispD = 1'b0;
    bit mCol = 1'b0;

    vga_sync_generator #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pixel_en(pixel_en),
        .counter_H(counter_H),
        .counter_V(counter_V),
        .hsync(hsync),
        .vsync(vsync),
        .display_on(display_on),
        .line_end(line_end),
        .frame_end(frame_end),
        .frame_count(frame_count),
        .colour_in(colour_in),
        .colour_out(colour_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one clock of stimulus, advance the model, then compare every output at the falling edge.
    task automatic applyStimulus(input bit rstN, input bit en, input bit col);
        reset     = rstN;
        pixel_en  = en;
        colour_in = col;
        @(posedge clk);
        if (!rstN) begin
            mPos = 0; mH = 0; mV = 0; mFc = 0;
            mHs = 1'b1; mVs = 1'b1; mDisp = 1'b0;
            mLe = 1'b0; mFe = 1'b0; mDispD = 1'b0;
        end else if (en) begin
            mDispD = mDisp;
            mPos   = (mPos + 1) % (HT * VT);
            if (mPos == 0) mFc = (mFc + 1) % 256;
            mH    = mPos % HT;
            mV    = mPos / HT;
            mHs   = !(mH >= HA + HF && mH < HA + HF + HS);
            mVs   = !(mV >= VA + VF && mV < VA + VF + VS);
            mDisp = (mH < HA) && (mV < VA);
            mLe   = (mH == HT - 1);
            mFe   = (mPos == HT * VT - 1);
        end else begin
            mLe = 1'b0;
            mFe = 1'b0;
        end
`ifdef VGA_BLANK_MASK_EN
        mCol = col & mDispD;
`else
        mCol = 1'b0;
`endif
        @(negedge clk);
        checkOutput("counter_H", 32'(counter_H), 32'(mH));
        checkOutput("counter_V", 32'(counter_V), 32'(mV));
        checkOutput("hsync", 32'(hsync), 32'(mHs));
        checkOutput("vsync", 32'(vsync), 32'(mVs));
        checkOutput("display_on", 32'(display_on), 32'(mDisp));
        checkOutput("line_end", 32'(line_end), 32'(mLe));
        checkOutput("frame_end", 32'(frame_end), 32'(mFe));
        checkOutput("frame_count", 32'(frame_count), 32'(mFc));
        checkOutput("colour_out", 32'(colour_out), 32'(mCol));
    endtask

    initial begin
        int hsLow, hsFirst, dispFall, leCount, leAt, colHigh;
        int vsLow, feCount, feH, feV, fcAtZero;
        bit prevDisp;
        bit pattern [4];

        // Reset held for five cycles: outputs at reset values, syncs inactive
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1);

        // Release: first enabled cycle presents (1,0) inside the active area
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("release counter_H", 32'(counter_H), 1);
        checkOutput("release counter_V", 32'(counter_V), 0);
        checkOutput("release display_on", 32'(display_on), 1);

        // One line of free running
        hsLow = 0; hsFirst = -1; dispFall = -1; leCount = 0; leAt = -1; colHigh = 0;
        prevDisp = display_on;
        for (int i = 0; i < HT - 1; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            if (!hsync) begin
                if (hsLow == 0) hsFirst = 32'(counter_H);
                hsLow++;
            end
            if (prevDisp && !display_on && dispFall < 0) dispFall = 32'(counter_H);
            prevDisp = display_on;
            if (line_end) begin
                leCount++;
                leAt = 32'(counter_H);
            end
            if (colour_out) colHigh++;
        end
        checkOutput("hsync low width", hsLow, 96);
        checkOutput("hsync low start", hsFirst, 656);
        checkOutput("display_on fall", dispFall, 640);
        checkOutput("line_end count", leCount, 1);
        checkOutput("line_end position", leAt, 799);
        checkOutput("wrap counter_H", 32'(counter_H), 0);
        checkOutput("wrap counter_V", 32'(counter_V), 1);
`ifdef VGA_BLANK_MASK_EN
        checkOutput("colour_out line 0 width", colHigh, 639);
`else
        checkOutput("colour_out line 0 width", colHigh, 0);
`endif

        // One full frame from (0,1) back round to (0,1)
        vsLow = 0; feCount = 0; feH = -1; feV = -1; fcAtZero = -1;
        for (int i = 0; i < HT * VT; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            if (!vsync) vsLow++;
            if (frame_end) begin
                feCount++;
                feH = 32'(counter_H);
                feV = 32'(counter_V);
            end
            if (counter_H == 10'd0 && counter_V == 10'd0) fcAtZero = 32'(frame_count);
        end
        checkOutput("vsync low cycles", vsLow, VS * HT);
        checkOutput("frame_end count", feCount, 1);
        checkOutput("frame_end H", feH, HT - 1);
        checkOutput("frame_end V", feV, VT - 1);
        checkOutput("frame_count at origin", fcAtZero, 1);

        // Toggle pixel_en 1,0,0,1 around the end of a line
        for (int i = 0; i < HT * VT && mH != 797; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        pattern[0] = 1'b1; pattern[1] = 1'b0; pattern[2] = 1'b0; pattern[3] = 1'b1;
        leCount = 0;
        for (int rep = 0; rep < 3; rep++) begin
            for (int k = 0; k < 4; k++) begin
                applyStimulus(1'b1, pattern[k], 1'($urandom_range(0, 1)));
                if (line_end) leCount++;
            end
        end
        checkOutput("toggle line_end count", leCount, 1);
        checkOutput("toggle final counter_H", 32'(counter_H), 3);

        // Reset mid-frame for a single cycle
        for (int i = 0; i < HT * VT && !(mH == 300 && mV == 5); i++) applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("midreset counter_H", 32'(counter_H), 0);
        checkOutput("midreset counter_V", 32'(counter_V), 0);
        checkOutput("midreset frame_count", 32'(frame_count), 0);
        checkOutput("midreset hsync", 32'(hsync), 1);
        checkOutput("midreset vsync", 32'(vsync), 1);
        checkOutput("midreset frame_end", 32'(frame_end), 0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("midreset release H", 32'(counter_H), 1);

        // Randomised enable, colour and occasional reset against the model
        for (int i = 0; i < 30000; i++) begin
            applyStimulus($urandom_range(0, 499) != 0, $urandom_range(0, 3) != 0,
                          1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/vga_sync_generator.md
Name: vga_sync_generator

Overview:
- Produces the VGA raster position and sync timing that drive the Picture Processing Unit's counter_H/counter_V inputs.
- Default timing is 640x480 @ 60 Hz on a 25 MHz pixel tick, with line/frame event pulses and a frame counter for game-logic pacing.
- Sits directly upstream of the PPU and alongside the VGA output pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active sync level (0 = active-low)

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-low
- pixel_en  in  1  pixel tick; counters advance only when high (tie high at 25 MHz)
- counter_H  out  10  current horizontal pixel, 0..H_TOTAL-1
- counter_V  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- display_on  out  1  high inside the active area
- line_end  out  1  one-cycle pulse on the last pixel of each line
- frame_end  out  1  one-cycle pulse on the last pixel of each frame
- frame_count  out  8  completed-frame counter
- colour_in  in  1  PPU pixel (used only with the optional feature)
- colour_out  out  1  blanked pixel (used only with the optional feature)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (reset==0 at a clk edge):
  - counter_H=0, counter_V=0, frame_count=0.
  - hsync=vsync=~SYNC_POL (inactive).
  - display_on=0, line_end=0, frame_end=0, colour_out=0.
- Reset is honoured mid-frame with no drain. The first enabled cycle after release moves the counters to H=1, V=0.
- All outputs are registered. Each is computed from the next counter values, so on any cycle every output is consistent with the counter_H/counter_V presented that cycle.
- pixel_en low: every register holds; line_end and frame_end are forced to 0 (pulses never stretch).
- pixel_en high:
  - If counter_H == H_TOTAL-1, then counter_H wraps to 0.
  - Otherwise counter_H increments by 1.
  - On that wrap, counter_V wraps to 0 from V_TOTAL-1; otherwise counter_V increments by 1.
- hsync = SYNC_POL while H_ACTIVE+H_FP <= counter_H <= H_ACTIVE+H_FP+H_SYNC-1 (656..751), else ~SYNC_POL.
- vsync = SYNC_POL while V_ACTIVE+V_FP <= counter_V <= V_ACTIVE+V_FP+V_SYNC-1 (490..491), else ~SYNC_POL.
  - vsync changes only at line boundaries, coincident with counter_H becoming 0.
- display_on = (counter_H < H_ACTIVE) && (counter_V < V_ACTIVE).
- line_end = 1 exactly on cycles where counter_H == H_TOTAL-1 and pixel_en is high.
- frame_end = line_end && (counter_V == V_TOTAL-1).
- frame_count increments (mod 256) on the cycle the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0). It reads 1 when (0,0) of the second frame is presented.
- Sync timing is unaffected by the PPU. Downstream, the PPU relies on counter_H changing at most once per clk, and this block guarantees that.

Optional Feature:
- Macro: VGA_BLANK_MASK_EN.
- Defined: adds a one-stage alignment register.
  - colour_out = colour_in && display_on_d, where display_on_d is display_on delayed 1 cycle. This matches the PPU's registered colour output latency.
  - display_on_d also holds when pixel_en is low.
  - colour_out is 0 in reset and in all blanking intervals.
- Undefined: colour_out is tied to 0, colour_in is ignored, and no extra register is inferred.

Test Plan:
- Hold reset low for 5 cycles, then release with pixel_en=1 -> during reset all outputs are at their reset values, with hsync=vsync=1. The first post-release cycle shows counter_H=1, counter_V=0, display_on=1.
- Free-run one line -> hsync is low for exactly 96 consecutive cycles starting at counter_H=656. display_on falls at counter_H=640. line_end is high only at counter_H=799, then counter_H=0 and counter_V=1.
- Free-run one full frame (420000 cycles) -> vsync is low for 1600 cycles, covering lines 490-491. frame_end pulses once at (799,524). frame_count goes 0->1 at (0,0).
- Toggle pixel_en 1,0,0,1 repeatedly around counter_H=799 -> counters advance only on enabled cycles. line_end is high for exactly one cycle. No output changes while disabled.
- Assert reset at counter_H=300, counter_V=200 for 1 cycle -> the next cycle shows counters 0/0, frame_count=0, syncs inactive, and no frame_end pulse.
- With VGA_BLANK_MASK_EN defined and colour_in=1 constant -> colour_out is 1 from one cycle after display_on rises until one cycle after it falls (counter_H 1..640 on lines 0..479), and 0 elsewhere. With the macro undefined, colour_out is always 0.
